sb_dbus: RTL and testbench
==========================

// Module: sb_dbus
// PURPOSE
//  Data-side system bus bridge directly downstream of the core's execute stage.
//  - Consumes the execute stage's load/store request: re/we, addr, byte mask, unsigned flag, wdata.
//  - Runs a req/gnt/rvalid transaction on the data memory bus.
//  - Returns lane-aligned, sign/zero-extended load data to the register file write port.
//  - Holds the core with stall_o while a transaction is outstanding.
// PARAMETERS
//  TIMEOUT_CYC  16  cycles without gnt or rvalid before the transaction is aborted with err_o (>=2)
//  CNT_W        5   width of the timeout counter; must hold TIMEOUT_CYC
// PORTS
//  clk            in   1   core clock, rising edge
//  rst            in   1   asynchronous, active-low reset
//  mem_re_i       in   1   load request from execute
//  mem_we_i       in   1   store request from execute
//  addr_i         in   32  byte address
//  byte_mask_i    in   4   size pattern, unshifted: 0001 byte, 0011 half, 1111 word
//  un_sign_i      in   1   1 = zero-extend load, 0 = sign-extend
//  wdata_i        in   32  store data, right-justified
//  stall_o        out  1   hold pc/pipeline registers
//  rdata_o        out  32  extended load data to regfile
//  done_o         out  1   one-cycle pulse: access finished
//  err_o          out  1   one-cycle pulse with done_o: timeout (or misalign, see CONFIGURATION)
//  bus_req_o      out  1   bus request
//  bus_we_o       out  1   1 = write
//  bus_addr_o     out  32  word address ({addr[31:2],2'b00})
//  bus_be_o       out  4   byte enables = byte_mask << addr[1:0] (upper overflow bits dropped)
//  bus_wdata_o    out  32  wdata_i << (8*addr[1:0])
//  bus_gnt_i      in   1   request accepted
//  bus_rvalid_i   in   1   read data valid
//  bus_rdata_i    in   32  read data, word-aligned
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; all outputs 0; counter 0; request latches 0.
//  - FSM states: IDLE, REQ, WAIT_R, DONE.
//  - IDLE:
//    - re|we seen: latch all request fields, go to REQ.
//    - re and we both set: treat as a load and ignore the write.
//  - REQ:
//    - bus_req_o=1; bus_we/addr/be/wdata driven from the latches and held stable until gnt.
//    - gnt on a write: go to DONE.
//    - gnt on a read: go to WAIT_R.
//    - gnt and rvalid in the same cycle on a read: capture data, go directly to DONE.
//  - WAIT_R:
//    - bus_req_o=0.
//    - On rvalid: data = bus_rdata_i >> (8*addr[1:0]), masked to the size.
//    - Extension: bit 7 (byte) or bit 15 (half) replicated unless un_sign. Word loads pass through unchanged.
//    - Register the result into rdata_o, go to DONE.
//  - DONE: done_o=1 for exactly one cycle, stall_o=0, return to IDLE.
//    - A new request may be accepted in the following cycle.
//  - stall_o is combinational: (IDLE & (re|we)) | REQ | WAIT_R.
//    - Latency: zero-wait bus gives write 2 cycles and read 3 cycles, from request to done_o.
//  - Timeout:
//    - The counter clears on entry to REQ/WAIT_R and increments every cycle in those states.
//    - At TIMEOUT_CYC-1: go to DONE with err_o=1. For a read, rdata_o=0.
//    - A late gnt/rvalid arriving after the abort is ignored.
//  - rdata_o holds its value until the next load completes; stores never modify it.
//  - Reset mid-transaction: immediate return to IDLE; bus_req_o drops asynchronously; no done_o is produced.
// CONFIGURATION
//  SB_ALIGN_CHK_EN defined:
//    - Misaligned access (half at addr[0]=1, word at addr[1:0]!=0) issues no bus cycle.
//    - FSM goes IDLE->DONE with err_o=1. rdata_o=0 for a load.
//  SB_ALIGN_CHK_EN undefined:
//    - No check. Access is issued with shifted be and data.
//    - Lanes shifted past byte 3 are silently dropped.
// TESTING
//  - Word load 0x100, gnt+rvalid immediate, rdata 0xDEADBEEF -> rdata_o=0xDEADBEEF; done_o at cycle 3; stall_o high 2 cycles.
//  - Signed byte load addr 0x103, rdata 0x80xxxxxx -> rdata_o=0xFFFFFF80. With un_sign=1 -> 0x00000080.
//  - Half store addr 0x102, wdata 0x1234 -> bus_be_o=1100, bus_wdata_o=0x12340000, bus_addr_o=0x100.
//  - gnt delayed 3 cycles -> bus_req_o and addr held constant throughout; stall_o stays high; done_o one cycle after gnt.
//  - No rvalid, TIMEOUT_CYC=16 -> done_o+err_o pulse; rdata_o=0; a late rvalid is ignored.
//  - Reset asserted in WAIT_R -> outputs 0 at once. Next load after release completes normally.
//    With SB_ALIGN_CHK_EN, word load at 0x102 -> err_o=1 and no bus_req_o.

Source files
------------

// File: rtl/sb_dbus.sv
// sb_dbus: data-side bus bridge between execute and the req/gnt/rvalid data bus.
// Ports: clk, rst (async active-low); execute request mem_re_i/mem_we_i/addr_i/
//   byte_mask_i/un_sign_i/wdata_i; core side stall_o/rdata_o/done_o/err_o;
//   bus side bus_req_o/bus_we_o/bus_addr_o/bus_be_o/bus_wdata_o,
//   bus_gnt_i/bus_rvalid_i/bus_rdata_i.
// Define SB_ALIGN_CHK_EN to fault misaligned half/word accesses without a bus cycle.
module sb_dbus #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  byte_mask_i,
  input  logic        un_sign_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ld_q;
  logic             un_q;
  logic [1:0]       off_q;
  logic [3:0]       mask_q;

  logic        acc;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] sh;
  logic [31:0] ld_data;
  logic        tmo;

  assign acc  = mem_re_i | mem_we_i;
  // Lanes shifted past byte 3 fall off the 4-bit result.
  assign be_n = byte_mask_i << addr_i[1:0];
  assign wd_n = wdata_i << {addr_i[1:0], 3'b000};
  assign tmo  = (cnt == CNT_W'(TIMEOUT_CYC - 1));

`ifdef SB_ALIGN_CHK_EN
  logic mis;
  assign mis = ((byte_mask_i == 4'b0011) & addr_i[0])
             | ((byte_mask_i == 4'b1111) & (|addr_i[1:0]));
`endif

  assign stall_o = ((state == IDLE) & acc)
                 | (state == REQ)
                 | (state == WAIT_R);

  // Word masks also carry bit 1, so test the widest size first.
  always_comb begin
    sh      = bus_rdata_i >> {off_q, 3'b000};
    ld_data = sh;
    if (mask_q[3])
      ld_data = sh;
    else if (mask_q[1])
      ld_data = {{16{~un_q & sh[15]}}, sh[15:0]};
    else
      ld_data = {{24{~un_q & sh[7]}}, sh[7:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ld_q        <= 1'b0;
      un_q        <= 1'b0;
      off_q       <= 2'b00;
      mask_q      <= 4'b0000;
      rdata_o     <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= 4'b0000;
      bus_wdata_o <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc) begin
            // A simultaneous re/we is a load.
            ld_q        <= mem_re_i;
            un_q        <= un_sign_i;
            off_q       <= addr_i[1:0];
            mask_q      <= byte_mask_i;
            bus_we_o    <= mem_we_i & ~mem_re_i;
            bus_addr_o  <= {addr_i[31:2], 2'b00};
            bus_be_o    <= be_n;
            bus_wdata_o <= wd_n;
            cnt         <= '0;
`ifdef SB_ALIGN_CHK_EN
            if (mis) begin
              state  <= DONE;
              done_o <= 1'b1;
              err_o  <= 1'b1;
              if (mem_re_i)
                rdata_o <= '0;
            end else begin
              state     <= REQ;
              bus_req_o <= 1'b1;
            end
`else
            state     <= REQ;
            bus_req_o <= 1'b1;
`endif
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            cnt       <= '0;
            if (!ld_q) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else if (bus_rvalid_i) begin
              rdata_o <= ld_data;
              state   <= DONE;
              done_o  <= 1'b1;
            end else begin
              state <= WAIT_R;
            end
          end else if (tmo) begin
            bus_req_o <= 1'b0;
            state     <= DONE;
            done_o    <= 1'b1;
            err_o     <= 1'b1;
            if (ld_q)
              rdata_o <= '0;
          end
        end
        WAIT_R: begin
          cnt <= cnt + 1'b1;
          if (bus_rvalid_i) begin
            rdata_o <= ld_data;
            state   <= DONE;
            done_o  <= 1'b1;
          end else if (tmo) begin
            rdata_o <= '0;
            state   <= DONE;
            done_o  <= 1'b1;
            err_o   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_dbus.sv
// tb_sb_dbus: directed bench for sb_dbus.
// Drives execute/bus stimulus and checks core/bus outputs against fixed values.
module tb_sb_dbus;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_re_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [3:0]  byte_mask_i = '0;
  logic        un_sign_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i = 1'b0;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  int total = 0;
  int bad = 0;

  sb_dbus #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i),
    .addr_i(addr_i), .byte_mask_i(byte_mask_i),
    .un_sign_i(un_sign_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o),
    .done_o(done_o), .err_o(err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  // Present a request in IDLE, step one edge, then withdraw it.
  task automatic issue(input logic re, input logic we,
                       input logic [31:0] a, input logic [3:0] m,
                       input logic un, input logic [31:0] wd);
    mem_re_i = re; mem_we_i = we; addr_i = a;
    byte_mask_i = m; un_sign_i = un; wdata_i = wd;
    @(posedge clk); #1;
    mem_re_i = 1'b0; mem_we_i = 1'b0;
  endtask

  // Step edges until done_o or the limit; n is the edge count.
  task automatic wait_done(input int lim, output int n);
    n = 0;
    while (n < lim && done_o !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({stall_o, done_o, err_o, bus_req_o, bus_we_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b exp=00000",
               {stall_o, done_o, err_o, bus_req_o, bus_we_o});
    end
    total++;
    if ({rdata_o, bus_addr_o, bus_wdata_o, bus_be_o} !== 100'b0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h/%b exp=0",
               rdata_o, bus_addr_o, bus_wdata_o, bus_be_o);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_load;
    bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1;
    bus_rdata_i = 32'hDEADBEEF;
    mem_re_i = 1'b1; addr_i = 32'h100;
    byte_mask_i = 4'b1111; un_sign_i = 1'b0;
    #1;
    total++;
    if (stall_o !== 1'b1) begin
      bad++; $display("FAIL wl_stall1 got=%b exp=1", stall_o);
    end
    @(posedge clk); #1;
    mem_re_i = 1'b0;
    total++;
    if ({bus_req_o, stall_o, done_o} !== 3'b110) begin
      bad++;
      $display("FAIL wl_req got=%b exp=110",
               {bus_req_o, stall_o, done_o});
    end
    total++;
    if (bus_addr_o !== 32'h100 || bus_we_o !== 1'b0) begin
      bad++;
      $display("FAIL wl_addr got=%h/%b exp=00000100/0",
               bus_addr_o, bus_we_o);
    end
    @(posedge clk); #1;
    total++;
    if ({done_o, err_o, stall_o, bus_req_o} !== 4'b1000) begin
      bad++;
      $display("FAIL wl_done got=%b exp=1000",
               {done_o, err_o, stall_o, bus_req_o});
    end
    total++;
    if (rdata_o !== 32'hDEADBEEF) begin
      bad++; $display("FAIL wl_data got=%h exp=deadbeef", rdata_o);
    end
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    @(posedge clk); #1;
    total++;
    if (done_o !== 1'b0) begin
      bad++; $display("FAIL wl_pulse got=%b exp=0", done_o);
    end
  endtask

  task automatic test_ext_load;
    int n;
    // Signed byte at lane 3, rvalid one cycle after gnt.
    bus_gnt_i = 1'b1;
    issue(1'b1, 1'b0, 32'h103, 4'b0001, 1'b0, 32'h0);
    @(posedge clk); #1;
    total++;
    if ({bus_req_o, stall_o, done_o} !== 3'b010) begin
      bad++;
      $display("FAIL sb_waitr got=%b exp=010",
               {bus_req_o, stall_o, done_o});
    end
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1;
    bus_rdata_i = 32'h80123456;
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0;
    total++;
    if (done_o !== 1'b1 || rdata_o !== 32'hFFFFFF80) begin
      bad++;
      $display("FAIL sb_data got=%b/%h exp=1/ffffff80", done_o, rdata_o);
    end
    @(posedge clk); #1;
    // Same byte zero-extended, immediate gnt+rvalid.
    bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1;
    issue(1'b1, 1'b0, 32'h103, 4'b0001, 1'b1, 32'h0);
    wait_done(40, n);
    total++;
    if (n !== 1 || rdata_o !== 32'h00000080) begin
      bad++;
      $display("FAIL ub_data got=%0d/%h exp=1/00000080", n, rdata_o);
    end
    @(posedge clk); #1;
    // Signed half at lane 2.
    bus_rdata_i = 32'hBEEF0000;
    issue(1'b1, 1'b0, 32'h102, 4'b0011, 1'b0, 32'h0);
    wait_done(40, n);
    total++;
    if (n !== 1 || rdata_o !== 32'hFFFFBEEF) begin
      bad++;
      $display("FAIL sh_data got=%0d/%h exp=1/ffffbeef", n, rdata_o);
    end
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_gnt_delay;
    issue(1'b0, 1'b1, 32'h102, 4'b0011, 1'b0, 32'h1234);
    total++;
    if (bus_be_o !== 4'b1100 || bus_wdata_o !== 32'h12340000) begin
      bad++;
      $display("FAIL st_lanes got=%b/%h exp=1100/12340000",
               bus_be_o, bus_wdata_o);
    end
    total++;
    if (bus_addr_o !== 32'h100 || bus_we_o !== 1'b1) begin
      bad++;
      $display("FAIL st_addr got=%h/%b exp=00000100/1",
               bus_addr_o, bus_we_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({bus_req_o, stall_o, done_o} !== 3'b110 ||
          bus_addr_o !== 32'h100) begin
        bad++;
        $display("FAIL st_hold%0d got=%b/%h exp=110/00000100",
                 i, {bus_req_o, stall_o, done_o}, bus_addr_o);
      end
    end
    bus_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus_gnt_i = 1'b0;
    total++;
    if ({done_o, err_o, stall_o, bus_req_o} !== 4'b1000) begin
      bad++;
      $display("FAIL st_done got=%b exp=1000",
               {done_o, err_o, stall_o, bus_req_o});
    end
    total++;
    if (rdata_o !== 32'hFFFFBEEF) begin
      bad++; $display("FAIL st_rdata got=%h exp=ffffbeef", rdata_o);
    end
    @(posedge clk); #1;
`ifndef SB_ALIGN_CHK_EN
    // Half at lane 3: upper lane drops off.
    issue(1'b0, 1'b1, 32'h103, 4'b0011, 1'b0, 32'h1234);
    total++;
    if (bus_be_o !== 4'b1000 || bus_wdata_o !== 32'h34000000) begin
      bad++;
      $display("FAIL st_ovf got=%b/%h exp=1000/34000000",
               bus_be_o, bus_wdata_o);
    end
    bus_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus_gnt_i = 1'b0;
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_timeout;
    int n;
    // Read: gnt, then rvalid never comes.
    bus_gnt_i = 1'b1;
    issue(1'b1, 1'b0, 32'h200, 4'b1111, 1'b0, 32'h0);
    wait_done(40, n);
    bus_gnt_i = 1'b0;
    total++;
    if (n !== 17 || err_o !== 1'b1 || done_o !== 1'b1) begin
      bad++;
      $display("FAIL to_rd got=%0d/%b/%b exp=17/1/1", n, err_o, done_o);
    end
    total++;
    if (rdata_o !== 32'h0 || stall_o !== 1'b0) begin
      bad++;
      $display("FAIL to_rdata got=%h/%b exp=0/0", rdata_o, stall_o);
    end
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h55555555;
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0;
    @(posedge clk); #1;
    total++;
    if (rdata_o !== 32'h0 || done_o !== 1'b0 || stall_o !== 1'b0) begin
      bad++;
      $display("FAIL to_late got=%h/%b/%b exp=0/0/0",
               rdata_o, done_o, stall_o);
    end
    // Store: gnt never comes.
    issue(1'b0, 1'b1, 32'h300, 4'b1111, 1'b0, 32'hA5A5A5A5);
    wait_done(40, n);
    total++;
    if (n !== 16 || err_o !== 1'b1 || bus_req_o !== 1'b0) begin
      bad++;
      $display("FAIL to_wr got=%0d/%b/%b exp=16/1/0",
               n, err_o, bus_req_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int n;
    // Reset while REQ is asserting bus_req_o.
    issue(1'b1, 1'b0, 32'h400, 4'b1111, 1'b0, 32'h0);
    total++;
    if (bus_req_o !== 1'b1) begin
      bad++; $display("FAIL rm_pre got=%b exp=1", bus_req_o);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({bus_req_o, stall_o, done_o} !== 3'b000) begin
      bad++;
      $display("FAIL rm_req got=%b exp=000",
               {bus_req_o, stall_o, done_o});
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    // Reset while waiting for rvalid.
    bus_gnt_i = 1'b1;
    issue(1'b1, 1'b0, 32'h400, 4'b1111, 1'b0, 32'h0);
    @(posedge clk); #1;
    bus_gnt_i = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if ({stall_o, done_o, err_o, bus_req_o} !== 4'b0 ||
        bus_addr_o !== 32'h0 || rdata_o !== 32'h0) begin
      bad++;
      $display("FAIL rm_waitr got=%b/%h/%h exp=0000/0/0",
               {stall_o, done_o, err_o, bus_req_o}, bus_addr_o, rdata_o);
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (done_o !== 1'b0) begin
      bad++; $display("FAIL rm_nodone got=%b exp=0", done_o);
    end
    bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1;
    bus_rdata_i = 32'h0BADF00D;
    issue(1'b1, 1'b0, 32'h104, 4'b1111, 1'b0, 32'h0);
    wait_done(40, n);
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    total++;
    if (n !== 1 || err_o !== 1'b0 || rdata_o !== 32'h0BADF00D) begin
      bad++;
      $display("FAIL rm_after got=%0d/%b/%h exp=1/0/0badf00d",
               n, err_o, rdata_o);
    end
    @(posedge clk); #1;
  endtask

`ifdef SB_ALIGN_CHK_EN
  task automatic test_misalign;
    bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1;
    bus_rdata_i = 32'h11223344;
    issue(1'b1, 1'b0, 32'h102, 4'b1111, 1'b0, 32'h0);
    total++;
    if ({done_o, err_o, bus_req_o} !== 3'b110 || rdata_o !== 32'h0) begin
      bad++;
      $display("FAIL ma_word got=%b/%h exp=110/0",
               {done_o, err_o, bus_req_o}, rdata_o);
    end
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset;
    test_word_load;
    test_ext_load;
    test_store_gnt_delay;
    test_timeout;
    test_reset_mid;
`ifdef SB_ALIGN_CHK_EN
    test_misalign;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
